// File: rtl/fault_map_recorder.sv
// Fault map recorder: drives one diagnosis pass over the loop chains,
// builds the PE fault bitmap and flags, then streams the bitmap into eNVM.
module fault_map_recorder #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
    parameter int CNT_WIDTH     = $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     diag_en,
    input  logic [SYSTOLIC_SIZE-1:0] single_pe_detection,
    input  logic [SYSTOLIC_SIZE-1:0] row_fault_detection,
    input  logic [SYSTOLIC_SIZE-1:0] column_fault_detection,
    input  logic [ADDR_WIDTH-1:0]    row_idx,
    output logic                     envm_wr_en,
    output logic [ADDR_WIDTH-1:0]    envm_wr_addr,
    output logic [SYSTOLIC_SIZE-1:0] envm_wr_data,
    input  logic                     envm_wr_ready,
    output logic                     busy,
    output logic                     done,
    output logic [SYSTOLIC_SIZE-1:0] row_fault_flag,
    output logic [SYSTOLIC_SIZE-1:0] col_fault_flag,
    output logic [CNT_WIDTH-1:0]     faulty_pe_count
);

    typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SYSTOLIC_SIZE-1);

    state_t                   state, state_nxt;
    logic [ADDR_WIDTH-1:0]    cap_cnt;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [SYSTOLIC_SIZE-1:0] fault_map [SYSTOLIC_SIZE];
    logic                     start_acc;
    logic                     wr_fire;

    function automatic logic [CNT_WIDTH-1:0] popcount(
        input logic [SYSTOLIC_SIZE-1:0] v
    );
        logic [CNT_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < SYSTOLIC_SIZE; i++)
            c = c + CNT_WIDTH'(v[i]);
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        diag_en    = 1'b0;
        envm_wr_en = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        start_acc  = 1'b0;
        wr_fire    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                diag_en = 1'b1;
                busy    = 1'b1;
                if (cap_cnt == LAST)
                    state_nxt = WRITE;
            end
            WRITE: begin
                envm_wr_en = 1'b1;
                busy       = 1'b1;
                wr_fire    = envm_wr_ready;
                if (envm_wr_ready && addr == LAST)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign envm_wr_addr = envm_wr_en ? addr : '0;
    assign envm_wr_data = envm_wr_en ? fault_map[addr] : '0;

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            cap_cnt         <= '0;
            addr            <= '0;
            row_fault_flag  <= '0;
            col_fault_flag  <= '0;
            faulty_pe_count <= '0;
            for (int i = 0; i < SYSTOLIC_SIZE; i++)
                fault_map[i] <= '0;
        end else begin
            if (diag_en) begin
                cap_cnt <= (cap_cnt == LAST) ? '0 : cap_cnt + ADDR_WIDTH'(1);
                if (int'(row_idx) < SYSTOLIC_SIZE)
                    fault_map[row_idx] <= fault_map[row_idx] | single_pe_detection;
                row_fault_flag <= row_fault_flag | row_fault_detection;
                col_fault_flag <= col_fault_flag | column_fault_detection;
                if (cap_cnt == LAST)
                    addr <= '0;
            end
            // Count only on the accepting edge so a stalled write is never double counted
            if (wr_fire) begin
                faulty_pe_count <= faulty_pe_count + popcount(fault_map[addr]);
                addr            <= (addr == LAST) ? '0 : addr + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fault_map_recorder.sv
// Directed bench for fault_map_recorder: a model builds the expected bitmap,
// eNVM writes are checked against a scoreboard queue.
module tb_fault_map_recorder;

    localparam int S  = 8;
    localparam int AW = $clog2(S);
    localparam int CW = $clog2(S*S+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          diag_en;
    logic [S-1:0]  pe;
    logic [S-1:0]  rfd;
    logic [S-1:0]  cfd;
    logic [AW-1:0] row_idx;
    logic          envm_wr_en;
    logic [AW-1:0] envm_wr_addr;
    logic [S-1:0]  envm_wr_data;
    logic          envm_wr_ready;
    logic          busy;
    logic          done;
    logic [S-1:0]  row_fault_flag;
    logic [S-1:0]  col_fault_flag;
    logic [CW-1:0] faulty_pe_count;

    fault_map_recorder #(.SYSTOLIC_SIZE(S)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .start                  (start),
        .diag_en                (diag_en),
        .single_pe_detection    (pe),
        .row_fault_detection    (rfd),
        .column_fault_detection (cfd),
        .row_idx                (row_idx),
        .envm_wr_en             (envm_wr_en),
        .envm_wr_addr           (envm_wr_addr),
        .envm_wr_data           (envm_wr_data),
        .envm_wr_ready          (envm_wr_ready),
        .busy                   (busy),
        .done                   (done),
        .row_fault_flag         (row_fault_flag),
        .col_fault_flag         (col_fault_flag),
        .faulty_pe_count        (faulty_pe_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [S-1:0]  d;
    } wr_t;

    wr_t          sb[$];
    logic [S-1:0] exp_map [S];
    logic [S-1:0] exp_row;
    logic [S-1:0] exp_col;
    logic [CW-1:0] exp_cnt;

`define CHK(tag, obs, exp) begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
        errors++; \
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
    end \
end

    always @(negedge clk) begin
        wr_t e;
        if (rst === 1'b0 && envm_wr_en === 1'b1 && envm_wr_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL wr_extra: observed addr %0h expected no write", envm_wr_addr);
            end else begin
                e = sb.pop_front();
                `CHK("wr_addr", envm_wr_addr, e.a)
                `CHK("wr_data", envm_wr_data, e.d)
            end
        end
    end

    task automatic drive_cap(input int mode, input int i);
        pe      = '0;
        rfd     = '0;
        cfd     = '0;
        row_idx = AW'(i);
        case (mode)
            1: begin
                row_idx = AW'(S-1-i);
                if (S-1-i == 3) pe = 8'h04;
            end
            2: begin
                if (i == 2) rfd = 8'h80;
                if (i == 5) cfd = 8'h01;
            end
            3: begin
                pe  = '1;
                rfd = '1;
                cfd = '1;
            end
            4: begin
                row_idx = AW'(i/2);
                pe      = S'(1) << i;
            end
            default: ;
        endcase
    endtask

    task automatic run_pass(input int mode, input int stall_addr,
                            input int stall_len, input bit busy_start,
                            input int abort_addr);
        int edges;
        int stall_left;
        int budget;
        bit start_sent;
        wr_t e;
        for (int r = 0; r < S; r++) exp_map[r] = '0;
        exp_row = '0;
        exp_col = '0;
        exp_cnt = '0;
        sb.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        `CHK("cap_busy", busy, 1'b1)
        for (int i = 0; i < S; i++) begin
            drive_cap(mode, i);
            start = busy_start && (i == 4);
            exp_map[row_idx] = exp_map[row_idx] | pe;
            exp_row = exp_row | rfd;
            exp_col = exp_col | cfd;
            `CHK("diag_en", diag_en, 1'b1)
            @(posedge clk); #1;
            edges++;
        end
        pe = '0; rfd = '0; cfd = '0; row_idx = '0; start = 1'b0;
        `CHK("diag_en_off", diag_en, 1'b0)
        `CHK("wr_en_on", envm_wr_en, 1'b1)
        for (int r = 0; r < S; r++) begin
            e.a = AW'(r);
            e.d = exp_map[r];
            sb.push_back(e);
            exp_cnt = exp_cnt + CW'($countones(exp_map[r]));
        end
        stall_left = stall_len;
        start_sent = 1'b0;
        budget     = 0;
        while (done !== 1'b1 && budget < 100) begin
            if (abort_addr >= 0 && int'(envm_wr_addr) == abort_addr) break;
            start = 1'b0;
            if (busy_start && !start_sent && int'(envm_wr_addr) == 2) begin
                start      = 1'b1;
                start_sent = 1'b1;
            end
            if (int'(envm_wr_addr) == stall_addr && stall_left > 0) begin
                envm_wr_ready = 1'b0;
                stall_left--;
                `CHK("stall_en", envm_wr_en, 1'b1)
                `CHK("stall_addr", int'(envm_wr_addr), stall_addr)
                `CHK("stall_data", envm_wr_data, exp_map[stall_addr])
            end else begin
                envm_wr_ready = 1'b1;
            end
            @(posedge clk); #1;
            edges++;
            budget++;
        end
        start = 1'b0;
        envm_wr_ready = 1'b1;
        if (abort_addr >= 0) begin
            `CHK("abort_reached", int'(envm_wr_addr), abort_addr)
            rst = 1'b1;
            start = 1'b1;
            envm_wr_ready = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            start = 1'b0;
            envm_wr_ready = 1'b1;
            sb.delete();
            `CHK("abort_diag_en", diag_en, 1'b0)
            `CHK("abort_wr_en", envm_wr_en, 1'b0)
            `CHK("abort_busy", busy, 1'b0)
            `CHK("abort_count", faulty_pe_count, CW'(0))
            `CHK("abort_row_flag", row_fault_flag, S'(0))
            for (int k = 0; k < 4; k++) begin
                `CHK("abort_no_done", done, 1'b0)
                `CHK("abort_idle", busy, 1'b0)
                @(posedge clk); #1;
            end
        end else begin
            `CHK("done", done, 1'b1)
            `CHK("latency", edges, 2*S + stall_len)
            `CHK("busy_in_done", busy, 1'b0)
            `CHK("count", faulty_pe_count, exp_cnt)
            `CHK("row_flag", row_fault_flag, exp_row)
            `CHK("col_flag", col_fault_flag, exp_col)
            `CHK("sb_empty", sb.size(), 0)
            @(posedge clk); #1;
            `CHK("done_pulse", done, 1'b0)
            `CHK("idle_busy", busy, 1'b0)
            `CHK("count_hold", faulty_pe_count, exp_cnt)
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pe = '0; rfd = '0; cfd = '0; row_idx = '0;
        envm_wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        `CHK("rst_diag_en", diag_en, 1'b0)
        `CHK("rst_wr_en", envm_wr_en, 1'b0)
        `CHK("rst_wr_addr", envm_wr_addr, AW'(0))
        `CHK("rst_wr_data", envm_wr_data, S'(0))
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_row_flag", row_fault_flag, S'(0))
        `CHK("rst_col_flag", col_fault_flag, S'(0))
        `CHK("rst_count", faulty_pe_count, CW'(0))
        @(posedge clk); #1;

        run_pass(0, -1, 0, 1'b0, -1);
        run_pass(1, -1, 0, 1'b0, -1);
        run_pass(4, 2, 3, 1'b0, -1);
        run_pass(2, -1, 0, 1'b0, -1);
        run_pass(3, -1, 0, 1'b1, -1);
        run_pass(3, -1, 0, 1'b1, 5);
        run_pass(1, 6, 2, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
